pipelined_logic_unit: RTL
=========================

Name: pipelined_logic_unit

Overview:
- Parametrised, pipelined bitwise logic unit for the datapath; the successor to the fixed 32-bit combinational XOR element.
- Supports width-generic AND/OR/XOR/NOR/XNOR/ANDN, plus a running XOR accumulator for checksum use.
- Results pass through a STAGES-deep register pipeline with valid/ready handshake on both sides and full backpressure.
- Each result carries zero and parity flags.

Parameters:
- WIDTH, 32, operand/result width in bits (>=1)
- STAGES, 2, pipeline depth = issue-to-result latency in cycles (>=1)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand beat offered
- in_ready  output  1  unit accepts beat this cycle
- op  input  3  operation select, sampled with operands
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- out_valid  output  1  result beat offered
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  operation result
- zero  output  1  result == 0
- parity  output  1  XOR-reduction of result (1 = odd popcount)
- acc  output  WIDTH  current accumulator value

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: all stage valid bits 0, out_valid=0, result=0, zero=0, parity=0, acc=0. in_ready is combinational and equals 1 while out_valid=0.
- Op encoding:
  - 0 AND: A&B
  - 1 OR: A|B
  - 2 XOR: A^B
  - 3 NOR: ~(A|B)
  - 4 XNOR: ~(A^B)
  - 5 ANDN: A&~B
  - 6 XACC: acc_next=acc^A; result=acc_next; B ignored
  - 7 CLRACC: acc_next=0; result=old acc
- Advance: adv = !out_valid || out_ready. in_ready = adv, purely combinational. There is no dependence of in_ready on in_valid.
- Accept: when in_valid && in_ready, the stage-1 register captures op result, zero and parity, with valid=1. When in_valid=0 && adv=1, stage 1 loads valid=0 (a bubble).
- Pipeline motion:
  - When adv=1, every stage k+1 loads stage k (valid and data).
  - When adv=0, all stages hold.
  - Bubbles are not collapsed.
- Outputs: the last stage drives out_valid, result, zero and parity. Latency is exactly STAGES cycles from acceptance to out_valid with no backpressure. Throughput is 1 beat/cycle.
- Accumulator:
  - Updates only on an accepted beat with op 6 or 7, in the acceptance cycle.
  - Back-to-back XACC beats chain correctly.
  - acc output is the register value, not the pipelined copy.
- Flags: computed from the result at stage 1 and carried alongside it. zero=~|result; parity=^result.
- Backpressure: while out_valid=1 && out_ready=0, result/flags/out_valid hold stable, in_ready=0, and acc is unchanged.
- Simultaneous events: out_valid=1 && out_ready=1 && in_valid=1 pops the output and accepts the new beat in the same cycle.
- Ops while stalled: op/A/B presented while in_ready=0 are ignored, including XACC/CLRACC (no acc change).
- Reset mid-operation: asserting rst flushes all in-flight beats (no output appears), and acc returns to 0 immediately, asynchronously.
- Widths: all ops are bitwise at WIDTH with no carries. STAGES=1 gives one register between input and output.

Test Plan:
1. Reset then XOR, STAGES=2: A=1000000007 (0x3B9ACA07), B=143 (0x8F), op=2, out_ready=1 -> two cycles later out_valid=1, result=0x3B9ACA88, zero=0, parity=1.
2. Back-to-back AND/OR/NOR: same A,B with op=0,1,3 on consecutive cycles -> consecutive outputs 0x00000007, 0x3B9ACA8F, 0xC4653570, one per cycle.
3. Accumulator: XACC A=0x0F0F0F0F, XACC A=0xFFFF0000, then CLRACC -> results 0x0F0F0F0F, 0xF0F00F0F, 0xF0F00F0F. acc ends at 0; next XACC A=0x1 gives 0x00000001.
4. Backpressure: fill pipe with 3 XOR beats, hold out_ready=0 for 5 cycles -> in_ready=0 and outputs stable throughout. Release -> remaining beats drain in order with no loss or duplication. An XACC offered during the stall leaves acc unchanged.
5. Flags: op=4 (XNOR) with A=B=0x12345678 -> result=0xFFFFFFFF, parity=0, zero=0. op=2 with A=B -> result=0, zero=1, parity=0.
6. Reset mid-flight: accept 2 beats, assert rst for 1 cycle before any output -> out_valid stays 0 afterwards and acc=0. The next accepted beat appears after exactly STAGES cycles.

Source files
------------

// File: rtl/pipelined_logic_unit.sv
// pipelined_logic_unit: pipelined bitwise logic unit with running XOR accumulator and zero/parity flags
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   operand handshake; op, A, B sampled on acceptance
//   out_valid/out_ready result handshake; result, zero, parity from the last stage
//   acc                 live accumulator register (not the pipelined copy)
module pipelined_logic_unit #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             parity,
    output logic [WIDTH-1:0] acc
);
    logic                          adv;
    logic [WIDTH-1:0]              res;
    logic [STAGES-1:0]             v;
    logic [STAGES-1:0][WIDTH+1:0]  d;
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;
    assign out_valid = v[STAGES-1];
    assign {result, zero, parity} = d[STAGES-1];
    // op 6 yields the post-update accumulator, op 7 the pre-clear value
    always_comb
        res = op == 3'd0 ? A & B :
              op == 3'd1 ? A | B :
              op == 3'd2 ? A ^ B :
              op == 3'd3 ? ~(A | B) :
              op == 3'd4 ? ~(A ^ B) :
              op == 3'd5 ? A & ~B :
              op == 3'd6 ? acc ^ A : acc;
    always_ff @(posedge clk or posedge rst)
        if (rst)
            acc <= '0;
        else if (in_valid && adv && op[2:1] == 2'b11)
            acc <= op[0] ? '0 : res;
    // whole pipe moves together on adv; bubbles are carried, not collapsed
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            v <= '0;
            d <= '0;
        end else if (adv) begin
            v[0] <= in_valid;
            d[0] <= {res, ~|res, ^res};
            for (int k = 1; k < STAGES; k++) begin
                v[k] <= v[k-1];
                d[k] <= d[k-1];
            end
        end
endmodule
